// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int LEN_W = 16;
  localparam int CHK_W = 8;
  localparam logic [CHK_W-1:0] CHK_EMPTY = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs stream bytes little-endian into a 32-bit word and folds them into
// the running XOR checksum.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [7:0]       i_byte,
  output logic [31:0]      o_word,
  output logic             o_word_full,
  output logic [CHK_W-1:0] o_chk
);

  logic [1:0]       r_idx;
  logic [31:0]      r_word;
  logic [CHK_W-1:0] r_chk;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_idx  <= '0;
      r_word <= '0;
      r_chk  <= CHK_EMPTY;
    end else if (i_clr) begin
      r_idx  <= '0;
      r_word <= '0;
      r_chk  <= CHK_EMPTY;
    end else if (i_en) begin
      r_idx                         <= r_idx + 2'd1;
      r_word[{r_idx, 3'b000} +: 8] <= i_byte;
      r_chk                         <= r_chk ^ i_byte;
    end
  end

  // Word as it will look once the byte on i_byte lands; lets the top capture
  // the complete word in the same cycle the last byte is accepted.
  always_comb begin
    o_word                        = r_word;
    o_word[{r_idx, 3'b000} +: 8] = i_byte;
  end

  assign o_word_full = i_en && (r_idx == 2'd3);
  assign o_chk       = r_chk;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives LEN/DATA/CHK byte stream, writes 32-bit words to the
// cpu instruction memory and releases the cpu once the checksum matches.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          MAX_WORDS = 512
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic        cpu_enable,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int WI_W = $clog2(MAX_WORDS + 1);

  state_e           r_state;
  logic [LEN_W-1:0] r_len;
  logic [WI_W-1:0]  r_widx;
  logic             r_wen, r_done, r_err, r_cpu_en;
  logic [63:0]      r_addr;
  logic [31:0]      r_wdata;

  logic             w_acc, w_start, w_byte_en, w_full, w_last;
  logic [LEN_W-1:0] w_n;
  logic [31:0]      w_word;
  logic [CHK_W-1:0] w_chk;

  assign rx_ready  = r_state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHK};
  assign busy      = r_state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_CHK};
  assign w_acc     = rx_valid && rx_ready;
  assign w_start   = start && (r_state inside {S_IDLE, S_DONE, S_ERROR});
  assign w_byte_en = w_acc && (r_state == S_DATA);
  assign w_n       = {rx_data, r_len[7:0]};
  assign w_last    = (LEN_W'(r_widx) + LEN_W'(1)) == r_len;

  word_assembler u_asm (
    .clk        (clk),
    .arst_n     (arst_n),
    .i_clr      (w_start),
    .i_en       (w_byte_en),
    .i_byte     (rx_data),
    .o_word     (w_word),
    .o_word_full(w_full),
    .o_chk      (w_chk)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_widx   <= '0;
      r_wen    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_cpu_en <= 1'b0;
    end else begin
      r_wen <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_state  <= S_LEN_LO;
            r_widx   <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cpu_en <= 1'b0;
          end
        end
        S_LEN_LO: begin
          if (w_acc) begin
            r_len[7:0] <= rx_data;
            r_state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_acc) begin
            r_len <= w_n;
            if (w_n == '0) begin
              r_state <= S_CHK;
            end else if (int'(w_n) > MAX_WORDS) begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_full) begin
            r_state <= S_WRITE;
            r_wen   <= 1'b1;
            r_addr  <= BASE_ADDR + (64'(r_widx) << 2);
            r_wdata <= w_word;
          end
        end
        S_WRITE: begin
          r_widx  <= r_widx + 1'b1;
          r_state <= w_last ? S_CHK : S_DATA;
        end
        S_CHK: begin
          if (w_acc) begin
            if (rx_data == w_chk) begin
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_cpu_en <= 1'b1;
            end else begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wen_ext    = r_wen;
  assign addr_ext   = r_addr;
  assign wdata_ext  = r_wdata;
  assign ren_ext    = 1'b0;
  assign done       = r_done;
  assign error      = r_err;
  assign cpu_enable = r_cpu_en;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table, hand-written corner
// sequences and randomized images against a stream-level reference model.
module tb_imem_loader;

  localparam int          MAXW = 512;
  localparam logic [63:0] BASE = 64'h0;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic        cpu_enable;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .addr_ext  (addr_ext),
    .wen_ext   (wen_ext),
    .ren_ext   (ren_ext),
    .wdata_ext (wdata_ext),
    .cpu_enable(cpu_enable),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  // write-port observer
  logic [63:0] log_addr[$];
  logic [31:0] log_data[$];
  int          wen_run = 0;
  int          wen_max = 0;
  bit          ready_in_write = 1'b0;

  initial forever begin
    @(negedge clk);
    if (wen_ext) begin
      log_addr.push_back(addr_ext);
      log_data.push_back(wdata_ext);
      wen_run++;
      if (rx_ready) ready_in_write = 1'b1;
    end else begin
      wen_run = 0;
    end
    if (wen_run > wen_max) wen_max = wen_run;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (act=running exp=finished)");
    $fatal(1);
  end

  // current image
  logic [15:0] cur_len;
  logic [31:0] cur_img[$];
  logic [7:0]  cur_chk;
  logic [63:0] exp_addr[$];
  logic [31:0] exp_data[$];

  typedef struct {
    logic [15:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  chk;
    bit          gaps;
    int          nw;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: act=%h exp=%h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc, ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      acc = rx_ready;
      tick();
      if (acc) ok = 1'b1;
    end
    rx_valid = 1'b0;
    if (!ok) chk("rx_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [7:0] img_xor();
    logic [7:0] x = 8'h00;
    foreach (cur_img[i]) x ^= cur_img[i][7:0] ^ cur_img[i][15:8] ^ cur_img[i][23:16] ^ cur_img[i][31:24];
    return x;
  endfunction

  // Reference: every word lands at BASE+4*i; done only if length fits and
  // the trailing byte equals the XOR of all data bytes.
  task automatic model(output int nw, output bit e_done, output bit e_err);
    exp_addr.delete();
    exp_data.delete();
    if (int'(cur_len) > MAXW) begin
      nw = 0; e_done = 1'b0; e_err = 1'b1;
    end else begin
      foreach (cur_img[i]) begin
        exp_addr.push_back(BASE + 64'(4 * i));
        exp_data.push_back(cur_img[i]);
      end
      nw     = cur_img.size();
      e_done = (cur_chk == img_xor());
      e_err  = !e_done;
    end
  endtask

  task automatic stream(input bit gaps, input int mid_start_at);
    logic [7:0] bq[$];
    bq.push_back(cur_len[7:0]);
    bq.push_back(cur_len[15:8]);
    if (int'(cur_len) <= MAXW) begin
      foreach (cur_img[i])
        for (int k = 0; k < 4; k++) bq.push_back(cur_img[i][8*k +: 8]);
      bq.push_back(cur_chk);
    end
    log_addr.delete();
    log_data.delete();
    wen_max = 0;
    ready_in_write = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_clears", {60'd0, busy, done, error, cpu_enable}, 64'b1000);
    foreach (bq[i]) begin
      if (i == mid_start_at) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      send_byte(bq[i]);
      if (gaps) tick();
    end
    repeat (3) tick();
  endtask

  task automatic check_result(input string tag, input int nw, input bit e_done, input bit e_err);
    int bad = 0;
    chk({tag, "_nwrites"}, log_addr.size(), nw);
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (i >= log_addr.size()) bad++;
      else begin
        if (i < 2) begin
          chk({tag, "_addr"}, log_addr[i], exp_addr[i]);
          chk({tag, "_data"}, {32'd0, log_data[i]}, {32'd0, exp_data[i]});
        end
        if (log_addr[i] !== exp_addr[i] || log_data[i] !== exp_data[i]) bad++;
      end
    end
    chk({tag, "_bad_words"}, bad, 0);
    chk({tag, "_done"}, done, e_done);
    chk({tag, "_error"}, error, e_err);
    chk({tag, "_cpu_enable"}, cpu_enable, e_done);
    chk({tag, "_idle_flags"}, {62'd0, busy, rx_ready}, 64'd0);
    chk({tag, "_wen_width"}, (wen_max > 1), 0);
    chk({tag, "_ready_in_write"}, ready_in_write, 0);
  endtask

  vec_t vt[6];

  initial begin
    int nw;
    bit e_done, e_err;

    // data bytes 13 00 00 00 93 00 10 00 XOR to 0x90
    vt[0] = '{16'd2,      32'h00000013, 32'h00100093, 8'h90, 1'b0, 2, 1'b1, 1'b0};
    vt[1] = '{16'd2,      32'h00000013, 32'h00100093, 8'h80, 1'b0, 2, 1'b0, 1'b1};
    vt[2] = '{16'h0201,   32'h0,        32'h0,        8'h00, 1'b0, 0, 1'b0, 1'b1};
    vt[3] = '{16'd0,      32'h0,        32'h0,        8'h00, 1'b0, 0, 1'b1, 1'b0};
    vt[4] = '{16'd0,      32'h0,        32'h0,        8'h5A, 1'b0, 0, 1'b0, 1'b1};
    vt[5] = '{16'd1,      32'hDEADBEEF, 32'h0,        8'h22, 1'b1, 1, 1'b1, 1'b0};

    repeat (3) tick();
    chk("rst_addr", addr_ext, 64'd0);
    chk("rst_wdata", {32'd0, wdata_ext}, 64'd0);
    chk("rst_flags", {56'd0, rx_ready, wen_ext, ren_ext, cpu_enable, busy, done, error, 1'b0}, 64'd0);
    arst_n = 1'b1;
    tick();

    foreach (vt[v]) begin
      cur_len = vt[v].len;
      cur_chk = vt[v].chk;
      cur_img.delete();
      if (int'(cur_len) <= MAXW && cur_len >= 1) cur_img.push_back(vt[v].w0);
      if (int'(cur_len) <= MAXW && cur_len >= 2) cur_img.push_back(vt[v].w1);
      model(nw, e_done, e_err);
      stream(vt[v].gaps, -1);
      check_result($sformatf("vec%0d", v), vt[v].nw, vt[v].exp_done, vt[v].exp_err);
    end

    // randomized images, some with a corrupted checksum
    for (int r = 0; r < 7; r++) begin
      cur_len = (r == 6) ? 16'(MAXW) : 16'($urandom_range(1, 6));
      cur_img.delete();
      for (int i = 0; i < int'(cur_len); i++) cur_img.push_back($urandom);
      cur_chk = img_xor();
      if ($urandom_range(0, 2) == 0) cur_chk ^= 8'(1 << $urandom_range(0, 7));
      model(nw, e_done, e_err);
      stream((r != 6) && $urandom_range(0, 1) == 1, -1);
      check_result($sformatf("rnd%0d", r), nw, e_done, e_err);
    end

    // start pulsed while in DATA (after two data bytes) is ignored
    cur_len = 16'd1;
    cur_img.delete();
    cur_img.push_back(32'h12345678);
    cur_chk = img_xor();
    model(nw, e_done, e_err);
    stream(1'b0, 4);
    check_result("mid_start", nw, e_done, e_err);

    // reset after two of four data bytes drops every output at once
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    chk("pre_rst_busy", busy, 1'b1);
    arst_n = 1'b0;
    #1;
    chk("midrst_addr", addr_ext, 64'd0);
    chk("midrst_wdata", {32'd0, wdata_ext}, 64'd0);
    chk("midrst_flags", {56'd0, rx_ready, wen_ext, ren_ext, cpu_enable, busy, done, error, 1'b0}, 64'd0);
    tick();
    arst_n = 1'b1;
    tick();

    cur_len = 16'd1;
    cur_img.delete();
    cur_img.push_back(32'hCAFE0042);
    cur_chk = img_xor();
    model(nw, e_done, e_err);
    stream(1'b0, -1);
    check_result("post_rst", nw, e_done, e_err);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
